// File: rtl/stream_mux_rr.sv
// ---------------------------------------------------------------------------
// stream_mux_rr
//
// Purpose:
//   Merges N_CH valid/ready input streams into one output stream using a
//   round-robin arbiter followed by a one-entry output register. The merged
//   stream feeds the serial bus master port, so each beat carries the index
//   of the channel it came from.
//
// Optional feature (compile-time macro STREAM_MUX_LOCK_EN):
//   When defined, a two-state packet-lock FSM (IDLE/LOCKED) keeps the grant
//   on one channel from the first beat of a packet until the beat carrying
//   in_last. When undefined, arbitration is per beat, in_last is only passed
//   through to out_last and the FSM is not built.
//
// Parameters:
//   WIDTH  data width per channel
//   N_CH   number of input channels (2..16)
//   CH_W   width of out_ch, derived from N_CH (leave at its default)
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rstn       asynchronous active-low reset
//   in_data    packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_last    per-channel end-of-packet flag
//   in_ready   per-channel ready (combinational)
//   out_data   registered beat data
//   out_valid  registered beat valid
//   out_last   registered end-of-packet flag of the beat
//   out_ch     registered index of the channel that supplied the beat
//   out_ready  downstream ready
// ---------------------------------------------------------------------------

`default_nettype none

module stream_mux_rr #(
    parameter int WIDTH = 8,
    parameter int N_CH  = 4,
    parameter int CH_W  = $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    input  logic [N_CH-1:0]         in_valid,
    input  logic [N_CH-1:0]         in_last,
    output logic [N_CH-1:0]         in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic                    out_last,
    output logic [CH_W-1:0]         out_ch,
    input  logic                    out_ready
);

    // Round-robin pointer: the channel that has first claim on the next grant.
    logic [CH_W-1:0]  rr_ptr;

    // Raw round-robin choice, before any packet lock is applied.
    logic [N_CH-1:0]  rr_grant;
    logic [CH_W-1:0]  rr_idx;

    // Final grant (one-hot or zero) and its index.
    logic [N_CH-1:0]  grant;
    logic [CH_W-1:0]  grant_idx;

    // Output slot can take a new beat this cycle.
    logic             slot_free;
    logic             accept;

    // Data and last flag of the granted channel.
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;

    // Pointer value after the granted channel, wrapping at N_CH-1.
    logic [CH_W-1:0]  ptr_next;
    logic             ptr_load;

`ifdef STREAM_MUX_LOCK_EN
    typedef enum logic {
        IDLE,
        LOCKED
    } lock_state_t;

    lock_state_t     state;
    logic [CH_W-1:0] lock_ch;
`endif

    // Round-robin search. Each channel's distance from rr_ptr (modulo N_CH)
    // is compared against the search offset, so the first valid channel at
    // or after rr_ptr wins and the search wraps naturally. Indices are only
    // ever compile-time loop constants, so no out-of-range select can occur
    // when N_CH is not a power of two.
    always_comb begin
        logic found;
        found    = 1'b0;
        rr_grant = '0;
        rr_idx   = '0;
        for (int off = 0; off < N_CH; off++) begin
            for (int i = 0; i < N_CH; i++) begin
                if (!found && in_valid[i] &&
                    (((i - int'(rr_ptr) + N_CH) % N_CH) == off)) begin
                    found       = 1'b1;
                    rr_grant[i] = 1'b1;
                    rr_idx      = CH_W'(i);
                end
            end
        end
    end

    // Final grant. While a packet is locked the grant is pinned to the
    // locked channel; if that channel drops valid the mux simply stalls
    // rather than serving anyone else.
    always_comb begin
        grant     = rr_grant;
        grant_idx = rr_idx;
`ifdef STREAM_MUX_LOCK_EN
        if (state == LOCKED) begin
            grant     = '0;
            grant_idx = lock_ch;
            for (int i = 0; i < N_CH; i++) begin
                if (CH_W'(i) == lock_ch) begin
                    grant[i] = in_valid[i];
                end
            end
        end
`endif
    end

    // Handshake. The slot is also held closed during reset so no source
    // sees ready while the mux is being cleared.
    assign slot_free = rstn && (!out_valid || out_ready);
    assign in_ready  = grant & {N_CH{slot_free}};
    assign accept    = |in_ready;

    // Select the granted channel's payload. grant is one-hot or zero, so an
    // OR of the masked lanes is enough and avoids a variable part-select.
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                sel_data = sel_data | in_data[i*WIDTH +: WIDTH];
                sel_last = sel_last | in_last[i];
            end
        end
    end

    // Next pointer value after the granted channel. The explicit wrap keeps
    // out-of-range pointer values from ever appearing for non power-of-two
    // channel counts.
    always_comb begin
        if (grant_idx == CH_W'(N_CH - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = grant_idx + CH_W'(1);
        end
    end

    // With packet lock the pointer only advances when a packet ends, so a
    // multi-beat packet counts as a single turn in the rotation.
`ifdef STREAM_MUX_LOCK_EN
    assign ptr_load = accept && sel_last;
`else
    assign ptr_load = accept;
`endif

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr <= '0;
        end else if (ptr_load) begin
            rr_ptr <= ptr_next;
        end
    end

    // One-entry output register. A new acceptance always reloads it, which
    // covers the simultaneous pop-and-push case without a bubble. When
    // nothing is accepted the beat is dropped only after downstream took it;
    // otherwise every out_* field stays frozen.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_ch    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_last  <= sel_last;
            out_ch    <= grant_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef STREAM_MUX_LOCK_EN
    // Packet lock FSM. A first beat without in_last locks onto its channel;
    // the beat carrying in_last releases it. A single-beat packet passes
    // through IDLE without ever locking.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            lock_ch <= '0;
        end else if (accept) begin
            case (state)
                IDLE: begin
                    if (!sel_last) begin
                        state   <= LOCKED;
                        lock_ch <= grant_idx;
                    end
                end
                LOCKED: begin
                    if (sel_last) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
// ---------------------------------------------------------------------------
// tb_stream_mux_rr
//
// Self-checking bench for stream_mux_rr (WIDTH=8, N_CH=4). A reference
// arbiter model predicts in_ready and pushes the expected beat into a
// scoreboard queue whenever it predicts an acceptance; beats leaving the DUT
// are popped and compared. Directed checks cover reset, fairness order,
// backpressure hold, pointer wrap, packet lock and reset mid-packet. The
// lock expectations follow STREAM_MUX_LOCK_EN, as the RTL does.
// ---------------------------------------------------------------------------

`timescale 1ns/1ps

module tb_stream_mux_rr;

    localparam int WIDTH = 8;
    localparam int N_CH  = 4;
    localparam int CH_W  = 2;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             last;
        int               ch;
    } beat_t;

    logic                  clk;
    logic                  rstn;
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH-1:0]       in_last;
    logic [N_CH-1:0]       in_ready;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic                  out_last;
    logic [CH_W-1:0]       out_ch;
    logic                  out_ready;

    // Per-channel payload the stimulus tasks place on in_data.
    logic [WIDTH-1:0] ch_data [N_CH];

    // Scoreboard and log of channel indices in the order they left the DUT.
    beat_t exp_q [$];
    int    ch_log [$];

    // Reference arbiter state.
    int   m_ptr;
    bit   m_locked;
    int   m_lock_ch;
    bit   m_out_valid;
    int   m_last_acc;

    int checks;
    int errors;

    stream_mux_rr #(
        .WIDTH (WIDTH),
        .N_CH  (N_CH)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_ptr       = 0;
        m_locked    = 1'b0;
        m_lock_ch   = 0;
        m_out_valid = 1'b0;
        m_last_acc  = -1;
        exp_q.delete();
    endtask

    // Drives one cycle of inputs at a negedge, checks the handshake a little
    // later (well before the next posedge), advances the model and returns
    // at the following negedge.
    task automatic applyStimulus(input logic [N_CH-1:0] valid,
                                 input logic [N_CH-1:0] last,
                                 input logic ready);
        int              g;
        int              c;
        bit              slot;
        logic [N_CH-1:0] exp_rdy;
        beat_t           b;
        for (int i = 0; i < N_CH; i++) begin
            in_data[i*WIDTH +: WIDTH] = ch_data[i];
        end
        in_valid  = valid;
        in_last   = last;
        out_ready = ready;
        #1;
        g = -1;
        if (m_locked) begin
            if (valid[m_lock_ch]) g = m_lock_ch;
        end else begin
            for (int off = 0; off < N_CH; off++) begin
                c = (m_ptr + off) % N_CH;
                if (g < 0 && valid[c]) g = c;
            end
        end
        slot    = !m_out_valid || ready;
        exp_rdy = '0;
        if (g >= 0 && slot) exp_rdy[g] = 1'b1;
        checkOutput("in_ready", 32'(in_ready), 32'(exp_rdy));
        checkOutput("out_valid", 32'(out_valid), 32'(m_out_valid));
        if (m_out_valid && ready) begin
            checkOutput("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                b = exp_q.pop_front();
                checkOutput("out_data", 32'(out_data), 32'(b.data));
                checkOutput("out_last", 32'(out_last), 32'(b.last));
                checkOutput("out_ch", 32'(out_ch), 32'(b.ch));
                ch_log.push_back(int'(out_ch));
            end
        end
        m_last_acc = -1;
        if (g >= 0 && slot) begin
            b.data = ch_data[g];
            b.last = last[g];
            b.ch   = g;
            exp_q.push_back(b);
            m_out_valid = 1'b1;
            m_last_acc  = g;
`ifdef STREAM_MUX_LOCK_EN
            if (!last[g]) begin
                m_locked  = 1'b1;
                m_lock_ch = g;
            end else begin
                m_locked = 1'b0;
                m_ptr    = (g + 1) % N_CH;
            end
`else
            m_ptr = (g + 1) % N_CH;
`endif
        end else if (ready) begin
            m_out_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    // Two idle cycles with ready high empty the output register.
    task automatic drain();
        applyStimulus('0, '0, 1'b1);
        applyStimulus('0, '0, 1'b1);
    endtask

    initial begin
        int exp_lock [4];
        int ch1_beats;
        logic [N_CH-1:0] lk;

        checks    = 0;
        errors    = 0;
        rstn      = 1'b0;
        in_data   = '0;
        in_valid  = '1;
        in_last   = '1;
        out_ready = 1'b1;
        for (int i = 0; i < N_CH; i++) ch_data[i] = WIDTH'(i);
        modelReset();

        // Reset with every channel requesting.
        @(negedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_ch", 32'(out_ch), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_out_last", 32'(out_last), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Fairness: all valid, single-beat packets, 12 cycles.
        $display("[TB] fairness");
        for (int k = 0; k < 12; k++) applyStimulus('1, '1, 1'b1);
        drain();
        checkOutput("fair_count", 32'(ch_log.size()), 32'd12);
        for (int k = 0; k < 8; k++) checkOutput("fair_seq", 32'(ch_log[k]), 32'(k % N_CH));

        // Backpressure on ch2: A5 must be held for five stalled cycles.
        $display("[TB] backpressure");
        ch_data[2] = 8'hA5;
        applyStimulus(4'b0100, '1, 1'b1);
        ch_data[2] = 8'h5A;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'b0100, '1, 1'b0);
            checkOutput("bp_hold_data", 32'(out_data), 32'hA5);
            checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        applyStimulus(4'b0100, '1, 1'b1);
        checkOutput("bp_next_data", 32'(out_data), 32'h5A);
        drain();

        // Wrap with sparse valids: pointer sits at 3 after ch2.
        $display("[TB] wrap");
        ch_log.delete();
        for (int k = 0; k < 4; k++) applyStimulus(4'b1001, '1, 1'b1);
        drain();
        checkOutput("wrap_count", 32'(ch_log.size()), 32'd4);
        for (int k = 0; k < 4; k++) checkOutput("wrap_seq", 32'(ch_log[k]), (k % 2 == 0) ? 32'd3 : 32'd0);

        // Three-beat packet on ch1 while ch0 and ch2 also request.
        $display("[TB] packet");
`ifdef STREAM_MUX_LOCK_EN
        exp_lock = '{1, 1, 1, 2};
`else
        exp_lock = '{1, 2, 0, 1};
`endif
        ch_log.delete();
        ch_data[0] = 8'h10;
        ch_data[1] = 8'h21;
        ch_data[2] = 8'h32;
        ch1_beats  = 0;
        for (int k = 0; k < 4; k++) begin
            lk    = 4'b1101;
            lk[1] = (ch1_beats == 2);
            applyStimulus(4'b0111, lk, 1'b1);
            if (m_last_acc == 1) ch1_beats++;
            ch_data[1] = ch_data[1] + 8'h01;
        end
        drain();
        checkOutput("pkt_count", 32'(ch_log.size()), 32'd4);
        for (int k = 0; k < 4; k++) checkOutput("pkt_seq", 32'(ch_log[k]), 32'(exp_lock[k]));

        // Asynchronous reset while a multi-beat packet is in flight.
        $display("[TB] reset mid-packet");
        applyStimulus(4'b0010, 4'b0000, 1'b1);
        checkOutput("mid_valid_before", 32'(out_valid), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_data", 32'(out_data), 32'd0);
        checkOutput("mid_rst_ch", 32'(out_ch), 32'd0);
        checkOutput("mid_rst_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        modelReset();
        ch_log.delete();
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) applyStimulus('1, '1, 1'b1);
        drain();
        checkOutput("post_rst_count", 32'(ch_log.size()), 32'd4);
        checkOutput("post_rst_first", 32'(ch_log[0]), 32'd0);
        checkOutput("post_rst_second", 32'(ch_log[1]), 32'd1);

        checkOutput("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
